serving_arbiter_n: RTL and testbench

- Parametrised N-master to 1-slave Wishbone-classic arbiter for the serving SoC.
- Successor to the fixed two-port ibus/dbus arbiter, with:
  - Registered grant and grant lock for the whole transaction.
  - Selectable fixed-priority or round-robin arbitration.
  - Optional bus-timeout error response.
- Sits between the CPU buses (plus extra masters such as a debug or DMA port) and the shared RAM port.

---
 rtl/serving_arbiter_n.sv | 146 ++++++++++++++
 tb/tb_serving_arbiter_n.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serving_arbiter_n.sv
// serving_arbiter_n: N-master to 1-slave Wishbone-classic arbiter.
// Grant is registered and held for the whole transaction. Winner selection
// is either fixed priority (index 0 highest) or round-robin. An optional
// timeout answers a stalled transaction with a one-cycle error pulse.
module serving_arbiter_n #(
    parameter int    NUM_MASTERS = 2,
    parameter int    AW          = 32,
    parameter int    DW          = 32,
    parameter string MODE        = "FIXED",
    parameter int    TIMEOUT     = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_MASTERS*AW-1:0]   i_m_adr,
    input  logic [NUM_MASTERS*DW-1:0]   i_m_dat,
    input  logic [NUM_MASTERS*DW/8-1:0] i_m_sel,
    input  logic [NUM_MASTERS-1:0]      i_m_we,
    input  logic [NUM_MASTERS-1:0]      i_m_stb,
    output logic [DW-1:0]               o_m_rdt,
    output logic [NUM_MASTERS-1:0]      o_m_ack,
    output logic [NUM_MASTERS-1:0]      o_m_err,
    output logic [NUM_MASTERS-1:0]      o_grant,
    output logic [AW-1:0]               o_s_adr,
    output logic [DW-1:0]               o_s_dat,
    output logic [DW/8-1:0]             o_s_sel,
    output logic                        o_s_we,
    output logic                        o_s_stb,
    input  logic [DW-1:0]               i_s_rdt,
    input  logic                        i_s_ack
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = DW / 8;
    localparam bit IS_RR = (MODE == "RR");
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_MASTERS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic          busy;
    logic          g_stb;
    logic          ack_hit;
    logic          tmo_hit;
    logic          any_req;
    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] ptr_next;
    int            idx;

    // Winner search: lowest index in FIXED mode, first requester at or after ptr in RR mode.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = IS_RR ? (int'(ptr_q) + i) % NUM_MASTERS : i;
            if (!found && i_m_stb[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign any_req  = |i_m_stb;
    assign busy     = (state_q == BUSY);
    assign g_stb    = i_m_stb[gidx_q];
    assign ack_hit  = busy && i_s_ack;
    // Timeout only fires when the slave stays silent; a same-cycle ack wins.
    assign tmo_hit  = (TIMEOUT > 0) && busy && !i_s_ack && (cnt_q == CNT_LAST);
    assign ptr_next = (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;

    // Slave side follows the granted master only while BUSY; zeros otherwise.
    assign o_s_adr = busy ? i_m_adr[gidx_q*AW +: AW] : '0;
    assign o_s_dat = busy ? i_m_dat[gidx_q*DW +: DW] : '0;
    assign o_s_sel = busy ? i_m_sel[gidx_q*SW +: SW] : '0;
    assign o_s_we  = busy && i_m_we[gidx_q];
    assign o_s_stb = busy && g_stb && !tmo_hit;

    // Responses are suppressed during reset so a late slave ack cannot leak out.
    assign o_m_ack = (ack_hit && !i_rst) ? grant_q : '0;
    assign o_m_err = (tmo_hit && !i_rst) ? grant_q : '0;
    assign o_grant = grant_q;
    assign o_m_rdt = i_s_rdt;

    // Next-state: arbitrate in IDLE, hold the grant in BUSY until ack, timeout or abort.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    gidx_d  = win;
                    grant_d = NUM_MASTERS'(1) << win;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (ack_hit || tmo_hit) begin
                    state_d = IDLE;
                    grant_d = '0;
                    if (IS_RR) begin
                        ptr_d = ptr_next;
                    end
                end else if (!g_stb) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serving_arbiter_n.sv
// Bench for serving_arbiter_n: a 2-master fixed-priority instance driven from
// a vector table, and a 4-master round-robin instance with TIMEOUT=4 driven by
// hand sequences and random traffic against a cycle-level reference model.
module tb_serving_arbiter_n;

    localparam int T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- fixed-priority instance ----------------
    logic        fx_rst;
    logic [63:0] fx_adr;
    logic [63:0] fx_dat;
    logic [7:0]  fx_sel;
    logic [1:0]  fx_we;
    logic [1:0]  fx_stb;
    logic [31:0] fx_rdt_o;
    logic [1:0]  fx_ack_o;
    logic [1:0]  fx_err_o;
    logic [1:0]  fx_grant;
    logic [31:0] fx_sadr;
    logic [31:0] fx_sdat;
    logic [3:0]  fx_ssel;
    logic        fx_swe;
    logic        fx_sstb;
    logic [31:0] fx_rdt;
    logic        fx_ack;

    serving_arbiter_n #(.NUM_MASTERS(2), .AW(32), .DW(32), .MODE("FIXED"), .TIMEOUT(0)) dut_fx (
        .i_clk(clk), .i_rst(fx_rst),
        .i_m_adr(fx_adr), .i_m_dat(fx_dat), .i_m_sel(fx_sel), .i_m_we(fx_we), .i_m_stb(fx_stb),
        .o_m_rdt(fx_rdt_o), .o_m_ack(fx_ack_o), .o_m_err(fx_err_o), .o_grant(fx_grant),
        .o_s_adr(fx_sadr), .o_s_dat(fx_sdat), .o_s_sel(fx_ssel), .o_s_we(fx_swe), .o_s_stb(fx_sstb),
        .i_s_rdt(fx_rdt), .i_s_ack(fx_ack)
    );

    // ---------------- round-robin instance ----------------
    logic         rr_rst;
    logic [127:0] rr_adr;
    logic [127:0] rr_dat;
    logic [15:0]  rr_sel;
    logic [3:0]   rr_we;
    logic [3:0]   rr_stb;
    logic [31:0]  rr_rdt_o;
    logic [3:0]   rr_ack_o;
    logic [3:0]   rr_err_o;
    logic [3:0]   rr_grant;
    logic [31:0]  rr_sadr;
    logic [31:0]  rr_sdat;
    logic [3:0]   rr_ssel;
    logic         rr_swe;
    logic         rr_sstb;
    logic [31:0]  rr_rdt;
    logic         rr_ack;

    serving_arbiter_n #(.NUM_MASTERS(4), .AW(32), .DW(32), .MODE("RR"), .TIMEOUT(T)) dut_rr (
        .i_clk(clk), .i_rst(rr_rst),
        .i_m_adr(rr_adr), .i_m_dat(rr_dat), .i_m_sel(rr_sel), .i_m_we(rr_we), .i_m_stb(rr_stb),
        .o_m_rdt(rr_rdt_o), .o_m_ack(rr_ack_o), .o_m_err(rr_err_o), .o_grant(rr_grant),
        .o_s_adr(rr_sadr), .o_s_dat(rr_sdat), .o_s_sel(rr_ssel), .o_s_we(rr_swe), .o_s_stb(rr_sstb),
        .i_s_rdt(rr_rdt), .i_s_ack(rr_ack)
    );

    // Reference model of the round-robin instance: owner is the master holding
    // the bus (-1 when nobody does), ptr the first master considered next,
    // wait the number of unanswered BUSY cycles so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_wait  = 0;

    logic [3:0] obs_grant = '0;
    logic [3:0] obs_ack   = '0;
    logic [3:0] obs_err   = '0;
    logic       obs_sstb  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle on the RR instance: drive, compare against the model, advance the model.
    task automatic rr_step(input logic [3:0] stb, input logic ack, input logic rst);
        logic [3:0]  eg, ema, eme, es;
        logic [31:0] ea, ed;
        logic        ew, estb;
        bit          tmo, found;
        int          cand;
        @(negedge clk);
        rr_stb = stb;
        rr_ack = ack;
        rr_rst = rst;
        rr_adr = {$urandom, $urandom, $urandom, $urandom};
        rr_dat = {$urandom, $urandom, $urandom, $urandom};
        rr_sel = 16'($urandom);
        rr_we  = 4'($urandom);
        rr_rdt = $urandom;
        #1;
        eg = '0; ema = '0; eme = '0; es = '0; ea = '0; ed = '0; ew = 1'b0; estb = 1'b0; tmo = 1'b0;
        if (m_owner >= 0) begin
            eg   = 4'(1 << m_owner);
            tmo  = (m_wait == T - 1) && !ack;
            ea   = rr_adr[m_owner*32 +: 32];
            ed   = rr_dat[m_owner*32 +: 32];
            es   = rr_sel[m_owner*4 +: 4];
            ew   = rr_we[m_owner];
            estb = stb[m_owner] && !tmo;
            if (ack && !rst) ema = eg;
            if (tmo && !rst) eme = eg;
        end
        chk("rr grant", rr_grant, eg);
        chk("rr m_ack", rr_ack_o, ema);
        chk("rr m_err", rr_err_o, eme);
        chk("rr s_stb", rr_sstb, estb);
        chk("rr s_adr", rr_sadr, ea);
        chk("rr s_dat", rr_sdat, ed);
        chk("rr s_sel", rr_ssel, es);
        chk("rr s_we", rr_swe, ew);
        chk("rr m_rdt", rr_rdt_o, rr_rdt);
        obs_grant = rr_grant;
        obs_ack   = rr_ack_o;
        obs_err   = rr_err_o;
        obs_sstb  = rr_sstb;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_wait = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                cand = (m_ptr + k) % 4;
                if (!found && stb[cand]) begin
                    found = 1'b1;
                    m_owner = cand;
                end
            end
            m_wait = 0;
        end else if (ack || tmo) begin
            m_ptr = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (!stb[m_owner]) begin
            m_owner = -1;
        end else begin
            m_wait++;
        end
    endtask

    typedef struct {
        logic [1:0]  stb;
        logic        ack;
        logic [1:0]  grant;
        logic [1:0]  mack;
        logic        sstb;
        logic [31:0] adr;
    } vec_t;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0004;

    vec_t       tbl[14];
    logic [3:0] got[5];
    logic [3:0] exp_rot[5];
    logic [3:0] exp_alt[4];
    logic [3:0] drop, want, err_vec, acks;
    logic       ack, rst, err_stb;
    int         n, errs, err_at;

    initial begin
        tbl[0]  = '{2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        tbl[1]  = '{2'b11, 1'b0, 2'b01, 2'b00, 1'b1, A0};
        tbl[2]  = '{2'b11, 1'b1, 2'b01, 2'b01, 1'b1, A0};
        tbl[3]  = '{2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        tbl[4]  = '{2'b10, 1'b0, 2'b10, 2'b00, 1'b1, A1};
        tbl[5]  = '{2'b10, 1'b1, 2'b10, 2'b10, 1'b1, A1};
        tbl[6]  = '{2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        tbl[7]  = '{2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0};
        tbl[8]  = '{2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        tbl[9]  = '{2'b11, 1'b0, 2'b01, 2'b00, 1'b1, A0};
        tbl[10] = '{2'b11, 1'b1, 2'b01, 2'b01, 1'b1, A0};
        tbl[11] = '{2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        tbl[12] = '{2'b10, 1'b1, 2'b10, 2'b10, 1'b1, A1};
        tbl[13] = '{2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_alt = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

        fx_rst = 1'b1; fx_adr = {A1, A0}; fx_dat = {32'hBBBB_0001, 32'hAAAA_0000};
        fx_sel = 8'hF3; fx_we = 2'b10; fx_stb = '0; fx_rdt = '0; fx_ack = 1'b0;
        rr_rst = 1'b1; rr_adr = '0; rr_dat = '0; rr_sel = '0; rr_we = '0;
        rr_stb = '0; rr_rdt = '0; rr_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fx_rst = 1'b0;
        rr_rst = 1'b0;

        // Fixed-priority contention, stray ack and re-arbitration.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            fx_stb = tbl[i].stb;
            fx_ack = tbl[i].ack;
            fx_rdt = $urandom;
            #1;
            chk($sformatf("fx[%0d] grant", i), fx_grant, tbl[i].grant);
            chk($sformatf("fx[%0d] m_ack", i), fx_ack_o, tbl[i].mack);
            chk($sformatf("fx[%0d] m_err", i), fx_err_o, 2'b00);
            chk($sformatf("fx[%0d] s_stb", i), fx_sstb, tbl[i].sstb);
            chk($sformatf("fx[%0d] s_adr", i), fx_sadr, tbl[i].adr);
            chk($sformatf("fx[%0d] m_rdt", i), fx_rdt_o, fx_rdt);
        end

        // Reset state of the RR instance.
        rr_step(4'b0000, 1'b0, 1'b0);
        chk("rr reset grant", obs_grant, 4'b0000);
        chk("rr reset s_stb", obs_sstb, 1'b0);

        // Round-robin rotation with all masters requesting.
        drop = '0; n = 0;
        for (int i = 0; i < 5; i++) got[i] = '0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            ack = (m_owner >= 0);
            rr_step(4'b1111 & ~drop, ack, 1'b0);
            drop = ack ? obs_grant : 4'b0000;
            if (ack) begin got[n] = obs_grant; n++; end
        end
        chk("rot count", n, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("rot grant[%0d]", i), got[i], exp_rot[i]);

        // Only masters 1 and 3 requesting.
        n = 0;
        for (int i = 0; i < 5; i++) got[i] = '0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            ack = (m_owner >= 0);
            rr_step(4'b1010 & ~drop, ack, 1'b0);
            drop = ack ? obs_grant : 4'b0000;
            if (ack) begin got[n] = obs_grant; n++; end
        end
        chk("alt count", n, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("alt grant[%0d]", i), got[i], exp_alt[i]);

        // Timeout: master 2 never answered.
        rr_step(4'b0000, 1'b0, 1'b1);
        errs = 0; err_at = -1; err_vec = '0; err_stb = 1'b1; acks = '0;
        for (int c = 0; c < 5; c++) begin
            rr_step(4'b0100, 1'b0, 1'b0);
            acks |= obs_ack;
            if (obs_err != 0) begin
                errs++; err_at = c; err_vec = obs_err; err_stb = obs_sstb;
            end
        end
        rr_step(4'b0000, 1'b0, 1'b0);
        chk("tmo err pulses", errs, 1);
        chk("tmo err cycle", err_at, 4);
        chk("tmo err vector", err_vec, 4'b0100);
        chk("tmo s_stb at err", err_stb, 1'b0);
        chk("tmo no ack", acks, 4'b0000);
        chk("tmo grant after", obs_grant, 4'b0000);

        // Ack in the same cycle the timeout would fire, then stray acks in IDLE.
        rr_step(4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) rr_step(4'b0010, 1'b0, 1'b0);
        rr_step(4'b0010, 1'b1, 1'b0);
        chk("tie m_ack", obs_ack, 4'b0010);
        chk("tie m_err", obs_err, 4'b0000);
        rr_step(4'b0000, 1'b1, 1'b0);
        chk("stray ack 1", obs_ack, 4'b0000);
        rr_step(4'b0000, 1'b1, 1'b0);
        chk("stray ack 2", obs_ack, 4'b0000);

        // Reset while the slave acks.
        rr_step(4'b0000, 1'b0, 1'b1);
        rr_step(4'b0001, 1'b0, 1'b0);
        rr_step(4'b0001, 1'b0, 1'b0);
        rr_step(4'b0001, 1'b1, 1'b1);
        chk("rst-ack m_ack", obs_ack, 4'b0000);
        chk("rst-ack m_err", obs_err, 4'b0000);
        rr_step(4'b0001, 1'b1, 1'b0);
        chk("post-rst s_stb", obs_sstb, 1'b0);
        chk("post-rst grant", obs_grant, 4'b0000);
        chk("post-rst m_ack", obs_ack, 4'b0000);
        rr_step(4'b0000, 1'b0, 1'b0);

        // Abort: master 2 drops stb mid-transaction; pointer must stay at 0.
        rr_step(4'b0000, 1'b0, 1'b1);
        rr_step(4'b0100, 1'b0, 1'b0);
        rr_step(4'b0100, 1'b0, 1'b0);
        chk("abort grant", obs_grant, 4'b0100);
        rr_step(4'b0000, 1'b0, 1'b0);
        chk("abort m_ack", obs_ack, 4'b0000);
        chk("abort s_stb", obs_sstb, 1'b0);
        rr_step(4'b1111, 1'b0, 1'b0);
        chk("abort idle grant", obs_grant, 4'b0000);
        rr_step(4'b1111, 1'b0, 1'b0);
        chk("abort ptr kept", obs_grant, 4'b0001);
        rr_step(4'b0000, 1'b1, 1'b0);

        // Random traffic against the model.
        want = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (want[k]) begin
                    if (obs_ack[k] || obs_err[k] || $urandom_range(15) == 0) want[k] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    want[k] = 1'b1;
                end
            end
            ack = (m_owner >= 0) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            rst = ($urandom_range(99) == 0);
            rr_step(want, ack, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
